// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// op codes, exception causes, FSM states and decode helpers.
package mem_lsu_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] EXC_LOAD_FAULT     = 32'd5;
  localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] EXC_STORE_FAULT    = 32'd7;

  localparam logic [31:0] ZERO     = 32'd0;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Byte-lane formatting for the load/store unit: store lane
// replication and byte enables, load extract and extension.
module mem_lsu_fmt
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [15:0] w_sh;

  assign w_sh = 16'(i_rdata >> {i_off, 3'b000});

  // Decode op into lane enables, store data and load data
  always_comb begin
    o_be    = 4'h0;
    o_wdata = i_sdata;
    o_ldata = i_rdata;
    case (i_op)
      MEM_LB: begin
        o_be    = 4'hF;
        o_ldata = {{24{w_sh[7]}}, w_sh[7:0]};
      end
      MEM_LH: begin
        o_be    = 4'hF;
        o_ldata = {{16{w_sh[15]}}, w_sh};
      end
      MEM_LW: begin
        o_be    = 4'hF;
      end
      MEM_LBU: begin
        o_be    = 4'hF;
        o_ldata = {24'd0, w_sh[7:0]};
      end
      MEM_LHU: begin
        o_be    = 4'hF;
        o_ldata = {16'd0, w_sh};
      end
      MEM_SB: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_sdata[7:0]}};
      end
      MEM_SH: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_sdata[15:0]}};
      end
      MEM_SW: begin
        o_be    = 4'hF;
      end
      default: begin
        o_be    = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: bus handshake FSM, timeout, stall.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  input  logic                   mem_we_i,
  input  logic                   flush_int_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   stall_o,
  output logic [DATA_WIDTH-1:0]  exception_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [ADDR_WIDTH-1:0]  bus_addr_o,
  output logic [DATA_WIDTH-1:0]  bus_wdata_o,
  output logic [3:0]             bus_be_o,
  input  logic                   bus_gnt_i,
  input  logic                   bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  bus_rdata_i,
  input  logic                   bus_err_i
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  lsu_state_e r_state;
  logic [7:0] r_cnt;
  logic       r_flushed;

  logic                  w_load;
  logic                  w_store;
  logic                  w_half;
  logic                  w_word;
  logic                  w_trap;
  logic                  w_go;
  logic                  w_tmo;
  logic                  w_kill;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_ldata;
  logic [ADDR_WIDTH-1:0] w_baddr;
  logic [DATA_WIDTH-1:0] w_fault;
  logic [DATA_WIDTH-1:0] w_misexc;

  assign w_load  = is_load(mem_op_i);
  assign w_store = is_store(mem_op_i);
  assign w_half  = (mem_op_i == MEM_LH) |
                   (mem_op_i == MEM_LHU) |
                   (mem_op_i == MEM_SH);
  assign w_word  = (mem_op_i == MEM_LW) |
                   (mem_op_i == MEM_SW);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = (w_half & mem_addr_i[0]) |
                  (w_word & (|mem_addr_i[1:0]));
  assign w_off  = mem_addr_i[1:0];
`else
  assign w_trap = 1'b0;
  assign w_off  = w_word ? 2'b00 :
                  w_half ? {mem_addr_i[1], 1'b0} :
                           mem_addr_i[1:0];
`endif

  assign w_go     = (w_load | w_store) & ~w_trap;
  assign w_tmo    = (r_cnt == TMO);
  assign w_kill   = r_flushed | flush_int_i;
  assign w_baddr  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_fault  = w_load ? DATA_WIDTH'(EXC_LOAD_FAULT)
                           : DATA_WIDTH'(EXC_STORE_FAULT);
  assign w_misexc = w_load ? DATA_WIDTH'(EXC_LOAD_MISALIGN)
                           : DATA_WIDTH'(EXC_STORE_MISALIGN);

  mem_lsu_fmt u_fmt (
    .i_op    (mem_op_i),
    .i_off   (w_off),
    .i_sdata (mem_data_i),
    .i_rdata (bus_rdata_i),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  // Handshake FSM with timeout counter and flush memory
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= LSU_IDLE;
      r_cnt     <= 8'd0;
      r_flushed <= 1'b0;
    end else begin
      unique case (r_state)
        LSU_IDLE: begin
          r_cnt     <= 8'd0;
          r_flushed <= 1'b0;
          if (!flush_int_i && w_go)
            r_state <= bus_gnt_i ? LSU_RESP : LSU_REQ;
        end
        LSU_REQ: begin
          if (flush_int_i || w_tmo) begin
            r_state <= LSU_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (bus_gnt_i)
              r_state <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (bus_rvalid_i || w_tmo) begin
            r_state   <= LSU_IDLE;
            r_cnt     <= 8'd0;
            r_flushed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (flush_int_i)
              r_flushed <= 1'b1;
          end
        end
        default: begin
          r_state <= LSU_IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Bus request, stall, writeback and exception outputs
  always_comb begin
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = 1'b0;
    reg_wdata_o = reg_wdata_i;
    stall_o     = 1'b0;
    exception_o = '0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = w_baddr;
    bus_wdata_o = w_wdata;
    bus_be_o    = w_be;
    if (rst_i) begin
      reg_waddr_o = '0;
      reg_wdata_o = '0;
      bus_addr_o  = '0;
      bus_wdata_o = '0;
      bus_be_o    = 4'h0;
    end else begin
      unique case (r_state)
        LSU_IDLE: begin
          if (!flush_int_i) begin
            if (w_trap) begin
              exception_o = w_misexc;
            end else if (w_go) begin
              bus_req_o = 1'b1;
              stall_o   = 1'b1;
            end else begin
              reg_we_o = reg_we_i;
            end
          end
        end
        LSU_REQ: begin
          if (!flush_int_i) begin
            if (w_tmo) begin
              exception_o = w_fault;
            end else begin
              bus_req_o = 1'b1;
              stall_o   = 1'b1;
            end
          end
        end
        LSU_RESP: begin
          if (bus_rvalid_i) begin
            if (!w_kill) begin
              if (bus_err_i) begin
                exception_o = w_fault;
              end else if (w_load) begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = w_ldata;
              end
            end
          end else if (w_tmo) begin
            if (!w_kill)
              exception_o = w_fault;
          end else begin
            stall_o = 1'b1;
          end
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
      bus_we_o = bus_req_o & mem_we_i;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
// Hand-computed expectations for loads, stores, faults, flush.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_op_i;
  logic        mem_we_i;
  logic        flush_int_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stall_o;
  logic [31:0] exception_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_lsu u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .reg_waddr_i  (reg_waddr_i),
    .reg_we_i     (reg_we_i),
    .reg_wdata_i  (reg_wdata_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_op_i     (mem_op_i),
    .mem_we_i     (mem_we_i),
    .flush_int_i  (flush_int_i),
    .reg_waddr_o  (reg_waddr_o),
    .reg_we_o     (reg_we_o),
    .reg_wdata_o  (reg_wdata_o),
    .stall_o      (stall_o),
    .exception_o  (exception_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .bus_err_i    (bus_err_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_in;
    mem_op_i     = MEM_NOP;
    mem_we_i     = 1'b0;
    mem_addr_i   = '0;
    mem_data_i   = '0;
    reg_we_i     = 1'b0;
    reg_waddr_i  = '0;
    reg_wdata_i  = '0;
    flush_int_i  = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    bus_err_i    = 1'b0;
  endtask

  task automatic set_op(input logic [3:0]  op,
                        input logic [31:0] addr,
                        input logic [31:0] data);
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_data_i  = data;
    mem_we_i    = (op >= MEM_SB) && (op <= MEM_SW);
    reg_we_i    = 1'b1;
    reg_waddr_i = 5'd9;
    reg_wdata_i = 32'h5555_0000;
  endtask

  task automatic do_load(input logic [3:0]  op,
                         input logic [31:0] addr,
                         input logic [31:0] rdata,
                         input logic [31:0] exp,
                         input logic [31:0] exp_addr,
                         input string       tag);
    set_op(op, addr, 32'h0);
    bus_gnt_i = 1'b1;
    settle;
    chk({tag, "_req"}, 32'(bus_req_o), 32'd1);
    chk({tag, "_stall0"}, 32'(stall_o), 32'd1);
    chk({tag, "_addr"}, bus_addr_o, exp_addr);
    chk({tag, "_be"}, 32'(bus_be_o), 32'hF);
    chk({tag, "_bwe"}, 32'(bus_we_o), 32'd0);
    tick;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rdata;
    settle;
    chk({tag, "_stall1"}, 32'(stall_o), 32'd0);
    chk({tag, "_we"}, 32'(reg_we_o), 32'd1);
    chk({tag, "_wdata"}, reg_wdata_o, exp);
    chk({tag, "_waddr"}, 32'(reg_waddr_o), 32'd9);
    tick;
    idle_in;
    settle;
    chk({tag, "_idle"}, 32'(stall_o), 32'd0);
  endtask

  task automatic do_tmo(input logic [3:0]  op,
                        input logic [31:0] code,
                        input string       tag);
    int n;
    n = 0;
    set_op(op, 32'h20, 32'h77);
    settle;
    for (int i = 0; i < 400; i++) begin
      if (!stall_o) break;
      n++;
      tick;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd256);
    chk({tag, "_exc"}, exception_o, code);
    chk({tag, "_req"}, 32'(bus_req_o), 32'd0);
    chk({tag, "_we"}, 32'(reg_we_o), 32'd0);
    tick;
    idle_in;
    reg_we_i     = 1'b1;
    reg_wdata_i  = 32'h1234;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD;
    settle;
    chk({tag, "_late_wd"}, reg_wdata_o, 32'h1234);
    chk({tag, "_late_exc"}, exception_o, 32'd0);
    chk({tag, "_late_st"}, 32'(stall_o), 32'd0);
    tick;
    idle_in;
  endtask

  initial begin
    idle_in;
    rst_i = 1'b1;
    set_op(MEM_LW, 32'h40, 32'h0);
    bus_gnt_i = 1'b1;
    settle;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_we", 32'(reg_we_o), 32'd0);
    chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
    chk("rst_exc", exception_o, 32'd0);
    tick;
    tick;
    idle_in;
    rst_i = 1'b0;
    tick;

    reg_we_i    = 1'b1;
    reg_waddr_i = 5'd7;
    reg_wdata_i = 32'hCAFE;
    settle;
    chk("nop_we", 32'(reg_we_o), 32'd1);
    chk("nop_wd", reg_wdata_o, 32'hCAFE);
    chk("nop_wa", 32'(reg_waddr_o), 32'd7);
    chk("nop_stall", 32'(stall_o), 32'd0);
    chk("nop_req", 32'(bus_req_o), 32'd0);
    tick;
    idle_in;

    do_load(MEM_LB, 32'h103, 32'h8012_3456,
            32'hFFFF_FF80, 32'h100, "lb");
    do_load(MEM_LBU, 32'h101, 32'h0000_F100,
            32'h0000_00F1, 32'h100, "lbu");
    do_load(MEM_LH, 32'h102, 32'h8765_4321,
            32'hFFFF_8765, 32'h100, "lh");
    do_load(MEM_LHU, 32'h102, 32'h8765_4321,
            32'h0000_8765, 32'h100, "lhu");

    set_op(MEM_SH, 32'h202, 32'h0000_BEEF);
    for (int i = 0; i < 4; i++) begin
      bus_gnt_i = (i == 3);
      settle;
      chk("sh_req", 32'(bus_req_o), 32'd1);
      chk("sh_addr", bus_addr_o, 32'h200);
      chk("sh_be", 32'(bus_be_o), 32'hC);
      chk("sh_wd", bus_wdata_o, 32'hBEEF_BEEF);
      chk("sh_bwe", 32'(bus_we_o), 32'd1);
      tick;
    end
    bus_gnt_i = 1'b0;
    settle;
    chk("sh_resp_req", 32'(bus_req_o), 32'd0);
    chk("sh_resp_st", 32'(stall_o), 32'd1);
    tick;
    bus_rvalid_i = 1'b1;
    settle;
    chk("sh_done_st", 32'(stall_o), 32'd0);
    chk("sh_done_we", 32'(reg_we_o), 32'd0);
    chk("sh_done_exc", exception_o, 32'd0);
    tick;
    idle_in;

    set_op(MEM_SB, 32'h201, 32'h0000_12A5);
    bus_gnt_i = 1'b1;
    settle;
    chk("sb_be", 32'(bus_be_o), 32'h2);
    chk("sb_wd", bus_wdata_o, 32'hA5A5_A5A5);
    tick;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    settle;
    chk("sb_we", 32'(reg_we_o), 32'd0);
    tick;
    idle_in;

    set_op(MEM_LW, 32'h10, 32'h0);
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_err_i    = 1'b1;
    bus_rdata_i  = 32'h1111;
    settle;
    chk("err_exc", exception_o, 32'd5);
    chk("err_we", 32'(reg_we_o), 32'd0);
    chk("err_st", 32'(stall_o), 32'd0);
    tick;
    idle_in;
    settle;
    chk("err_idle_st", 32'(stall_o), 32'd0);
    chk("err_idle_exc", exception_o, 32'd0);

    do_tmo(MEM_LW, 32'd5, "tmo_ld");
    do_tmo(MEM_SW, 32'd7, "tmo_st");

    set_op(MEM_LW, 32'h30, 32'h0);
    settle;
    tick;
    flush_int_i = 1'b1;
    settle;
    chk("flq_req", 32'(bus_req_o), 32'd0);
    chk("flq_st", 32'(stall_o), 32'd0);
    chk("flq_we", 32'(reg_we_o), 32'd0);
    tick;
    idle_in;
    settle;
    chk("flq_idle", 32'(stall_o), 32'd0);
    tick;

    set_op(MEM_LW, 32'h34, 32'h0);
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i   = 1'b0;
    flush_int_i = 1'b1;
    settle;
    chk("flr_st", 32'(stall_o), 32'd1);
    tick;
    flush_int_i  = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h4242;
    settle;
    chk("flr_done_st", 32'(stall_o), 32'd0);
    chk("flr_done_we", 32'(reg_we_o), 32'd0);
    chk("flr_done_exc", exception_o, 32'd0);
    tick;
    idle_in;
    settle;
    chk("flr_idle", 32'(stall_o), 32'd0);
    tick;

`ifdef MEM_MISALIGN_TRAP_EN
    set_op(MEM_LW, 32'h2, 32'h0);
    bus_gnt_i = 1'b1;
    settle;
    chk("mis_exc", exception_o, 32'd4);
    chk("mis_req", 32'(bus_req_o), 32'd0);
    chk("mis_st", 32'(stall_o), 32'd0);
    chk("mis_we", 32'(reg_we_o), 32'd0);
    tick;
    idle_in;
`else
    do_load(MEM_LW, 32'h2, 32'h1122_3344,
            32'h1122_3344, 32'h0, "lw_unal");
    do_load(MEM_LH, 32'h103, 32'h8765_4321,
            32'hFFFF_8765, 32'h100, "lh_unal");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
